// File: rtl/perip_bus_arbiter.sv
// Two-master arbiter for the shared DRAM/MMIO peripheral bus.
// M0 (CPU data port) wins ties from idle; a burst cap bounds how long one master can hold
// the bus while the other waits. Read data is returned to the issuing master via a tagged
// delay line matching the bus read latency.
module perip_bus_arbiter #(
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // Master 0
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wen,
  input  logic [1:0]  m0_mask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  // Master 1
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wen,
  input  logic [1:0]  m1_mask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  // Peripheral bus
  output logic [31:0] perip_addr,
  output logic [31:0] perip_wdata,
  output logic        perip_wen,
  output logic [1:0]  perip_mask,
  input  logic [31:0] perip_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } state_e;

  localparam logic [3:0] MaxCnt = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Return delay line: stage 0 is loaded at issue, the last stage drives rvalid.
  logic [READ_LATENCY-1:0] ret_vld_q;
  logic [READ_LATENCY-1:0] ret_id_q;
  logic                    ret_push;
  logic                    ret_id;

  // Grant decision and owner/burst-count next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (m0_req) begin
            m0_gnt  = 1'b1;
            state_d = StOwn0;
            cnt_d   = 4'd1;
          end else if (m1_req) begin
            m1_gnt  = 1'b1;
            state_d = StOwn1;
            cnt_d   = 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        StOwn0: begin
          if (m0_req && (!m1_req || cnt_q < MaxCnt)) begin
            m0_gnt = 1'b1;
            cnt_d  = (cnt_q < MaxCnt) ? cnt_q + 4'd1 : MaxCnt;
          end else if (m1_req) begin
            m1_gnt  = 1'b1;
            state_d = StOwn1;
            cnt_d   = 4'd1;
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StOwn1: begin
          if (m1_req && (!m0_req || cnt_q < MaxCnt)) begin
            m1_gnt = 1'b1;
            cnt_d  = (cnt_q < MaxCnt) ? cnt_q + 4'd1 : MaxCnt;
          end else if (m0_req) begin
            m0_gnt  = 1'b1;
            state_d = StOwn0;
            cnt_d   = 4'd1;
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Bus mux: granted master drives the bus, otherwise everything is held at zero.
  always_comb begin
    perip_addr  = 32'h0;
    perip_wdata = 32'h0;
    perip_wen   = 1'b0;
    perip_mask  = 2'b00;
    if (m0_gnt) begin
      perip_addr  = m0_addr;
      perip_wdata = m0_wdata;
      perip_wen   = m0_wen;
      perip_mask  = m0_mask;
    end else if (m1_gnt) begin
      perip_addr  = m1_addr;
      perip_wdata = m1_wdata;
      perip_wen   = m1_wen;
      perip_mask  = m1_mask;
    end
  end

  // Tag each issued read with the issuing master.
  always_comb begin
    ret_push = (m0_gnt && !m0_wen) || (m1_gnt && !m1_wen);
    ret_id   = m1_gnt;
  end

  // Owner FSM, burst counter and read-return delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      ret_vld_q <= '0;
      ret_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ret_vld_q[0] <= ret_push;
      ret_id_q[0]  <= ret_id;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        ret_vld_q[i] <= ret_vld_q[i-1];
        ret_id_q[i]  <= ret_id_q[i-1];
      end
    end
  end

  // Route the returning read to its master; rdata is a plain fan-out of the bus.
  always_comb begin
    m0_rvalid = rst_n && ret_vld_q[READ_LATENCY-1] && !ret_id_q[READ_LATENCY-1];
    m1_rvalid = rst_n && ret_vld_q[READ_LATENCY-1] &&  ret_id_q[READ_LATENCY-1];
    m0_rdata  = perip_rdata;
    m1_rdata  = perip_rdata;
  end

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Scoreboard bench for perip_bus_arbiter: directed scenarios followed by random traffic.
module tb_perip_bus_arbiter;

  localparam int MB = 4;
  localparam int L  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  mask;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        g0;
    logic        g1;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  mask;
  } bus_t;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_wen, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_mask;
  logic        m1_req, m1_wen, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_mask;
  logic [31:0] perip_addr, perip_wdata, perip_rdata;
  logic        perip_wen;
  logic [1:0]  perip_mask;

  perip_bus_arbiter #(
    .MAX_BURST   (MB),
    .READ_LATENCY(L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wen     (m0_wen),
    .m0_mask    (m0_mask),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wen     (m1_wen),
    .m1_mask    (m1_mask),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .perip_addr (perip_addr),
    .perip_wdata(perip_wdata),
    .perip_wen  (perip_wen),
    .perip_mask (perip_mask),
    .perip_rdata(perip_rdata)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bus_t exp_q[$];
  rd_t  rdq[$];

  // Reference model state: current owner (-1 = none) and length of its current run.
  int owner = -1;
  int run   = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic txn_t rd(input logic [31:0] a);
    txn_t t;
    t.addr  = a;
    t.wdata = 32'h0;
    t.wen   = 1'b0;
    t.mask  = 2'b10;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.wen   = 1'($urandom_range(0, 1));
    t.mask  = 2'($urandom_range(0, 2));
    return t;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, run the reference model, queue the expected response.
  task automatic step(input logic r0, input txn_t t0, input logic r1, input txn_t t1,
                      input logic rst_v, output int g);
    bus_t e;
    txn_t t;
    logic own_req, oth_req;
    @(negedge clk);
    cyc++;
    rst_n    = rst_v;
    m0_req   = r0;
    m0_addr  = t0.addr;
    m0_wdata = t0.wdata;
    m0_wen   = t0.wen;
    m0_mask  = t0.mask;
    m1_req   = r1;
    m1_addr  = t1.addr;
    m1_wdata = t1.wdata;
    m1_wen   = t1.wen;
    m1_mask  = t1.mask;
    g = -1;
    if (!rst_v) begin
      owner = -1;
      run   = 0;
      rdq.delete();
    end else begin
      if (owner < 0) begin
        g = r0 ? 0 : (r1 ? 1 : -1);
      end else begin
        own_req = (owner == 0) ? r0 : r1;
        oth_req = (owner == 0) ? r1 : r0;
        if (own_req && (!oth_req || run < MB)) g = owner;
        else if (oth_req) g = 1 - owner;
      end
      if (g < 0) begin
        owner = -1;
        run   = 0;
      end else if (g == owner) begin
        run = (run < MB) ? run + 1 : MB;
      end else begin
        owner = g;
        run   = 1;
      end
    end
    // Memory answers the read that is due this cycle; otherwise the bus carries noise.
    if (rdq.size() > 0 && rdq[0].due == cyc) perip_rdata = mem(rdq[0].addr);
    else perip_rdata = $urandom;
    t       = (g == 1) ? t1 : t0;
    e.cyc   = cyc;
    e.g0    = (g == 0);
    e.g1    = (g == 1);
    e.addr  = (g >= 0) ? t.addr : 32'h0;
    e.wdata = (g >= 0) ? t.wdata : 32'h0;
    e.wen   = (g >= 0) ? t.wen : 1'b0;
    e.mask  = (g >= 0) ? t.mask : 2'b00;
    exp_q.push_back(e);
    if (g >= 0 && !t.wen) rdq.push_back('{due: cyc + L, id: g, addr: t.addr});
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1, g);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation, mid-cycle.
  initial begin
    bus_t e;
    rd_t  r;
    logic ev0, ev1;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_gnt", e.cyc, 32'(m0_gnt), 32'(e.g0));
        chk("m1_gnt", e.cyc, 32'(m1_gnt), 32'(e.g1));
        chk("perip_addr", e.cyc, perip_addr, e.addr);
        chk("perip_wdata", e.cyc, perip_wdata, e.wdata);
        chk("perip_wen_mask", e.cyc, {29'h0, perip_wen, perip_mask}, {29'h0, e.wen, e.mask});
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (rdq.size() > 0 && rdq[0].due == e.cyc) begin
          r   = rdq.pop_front();
          ev0 = (r.id == 0);
          ev1 = (r.id == 1);
          if (ev0) chk("m0_rdata", e.cyc, m0_rdata, mem(r.addr));
          else     chk("m1_rdata", e.cyc, m1_rdata, mem(r.addr));
        end
        chk("m0_rvalid", e.cyc, 32'(m0_rvalid), 32'(ev0));
        chk("m1_rvalid", e.cyc, 32'(m1_rvalid), 32'(ev1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    txn_t c0, c1;
    logic p0, p1;
    txn_t wr;
    rst_n       = 1'b0;
    m0_req      = 1'b0;
    m1_req      = 1'b0;
    {m0_addr, m0_wdata, m0_wen, m0_mask} = '0;
    {m1_addr, m1_wdata, m1_wen, m1_mask} = '0;
    perip_rdata = 32'h0;

    // Reset with requests asserted: everything must stay quiet.
    step(1'b1, rd(32'h4), 1'b1, rd(32'h8), 1'b0, g);
    step(1'b1, rd(32'h4), 1'b1, rd(32'h8), 1'b0, g);

    // M0 alone: six back-to-back reads.
    for (int i = 0; i < 6; i++) step(1'b1, rd(32'(i * 4)), 1'b0, '0, 1'b1, g);
    idle(L + 1);

    // Both masters requesting continuously from idle.
    c0 = rnd_txn();
    c1 = rnd_txn();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, c0, 1'b1, c1, 1'b1, g);
      if (g == 0) c0 = rnd_txn();
      if (g == 1) c1 = rnd_txn();
    end
    idle(L + 1);

    // M1 word write.
    wr.addr  = 32'h8000_0000;
    wr.wdata = 32'hDEAD_BEEF;
    wr.wen   = 1'b1;
    wr.mask  = 2'b10;
    step(1'b0, '0, 1'b1, wr, 1'b1, g);
    idle(L + 1);

    // Interleaved reads from alternating masters.
    step(1'b1, rd(32'h10), 1'b0, '0, 1'b1, g);
    step(1'b0, '0, 1'b1, rd(32'h20), 1'b1, g);
    step(1'b1, rd(32'h30), 1'b0, '0, 1'b1, g);
    idle(L + 1);

    // Reset pulse with a read in flight.
    step(1'b1, rd(32'h40), 1'b0, '0, 1'b1, g);
    step(1'b0, '0, 1'b0, '0, 1'b0, g);
    idle(L + 2);

    // Random traffic: requests held until granted, occasionally withdrawn, rare resets.
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1'b1; c0 = rnd_txn(); end
      if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1'b1; c1 = rnd_txn(); end
      if (p0 && $urandom_range(0, 15) == 0) p0 = 1'b0;
      if (p1 && $urandom_range(0, 15) == 0) p1 = 1'b0;
      step(p0, c0, p1, c1, ($urandom_range(0, 63) != 0), g);
      if (g == 0) p0 = 1'b0;
      if (g == 1) p1 = 1'b0;
    end
    idle(L + 2);

    @(negedge clk);
    #5;
    n_vec++;
    if (exp_q.size() != 0 || rdq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d bus / %0d read expectations left, expected 0/0",
               exp_q.size(), rdq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
